muldiv_ctrl: RTL and testbench

//  Issue-side controller for the M-extension unit. Accepts one RV32M op per cycle from the issue

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_ctrl_div_iter.sv | 147 ++++++++++++++
 rtl/muldiv_ctrl.sv | 116 +++++++++++
 tb/tb_muldiv_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// RV32M controller shared definitions.
// funct3 codes, divider state encoding, default tag width.
package muldiv_pkg;

  localparam int TAG_W_DEF = 5;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    D_IDLE,
    D_BUSY,
    D_DONE
  } div_state_e;

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports: start_i/rs1_i/rs2_i/funct3_i/tag_i in, grant_i/kill_i in,
// done_o/idle_o/result_o/tag_o out.
module div_iter
  import muldiv_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [31:0]      rs1_i,
  input  logic [31:0]      rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             grant_i,
  input  logic             kill_i,
  output logic             done_o,
  output logic             idle_o,
  output logic [31:0]      result_o,
  output logic [TAG_W-1:0] tag_o
);

  div_state_e state_q, state_d;

  logic [4:0]       cnt_q;
  logic [31:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      dvsr_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             is_rem_q;
  logic [TAG_W-1:0] tag_q;

  logic        sgn;
  logic        div0;
  logic        ovf;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] first_step;
  logic [63:0] next_step;

  // One restoring step: shift in the next dividend bit and
  // subtract when the partial remainder covers the divisor.
  function automatic logic [63:0] div_step(
    input logic [31:0] rem,
    input logic [31:0] quo,
    input logic [31:0] d
  );
    logic [32:0] sh;
    logic [31:0] sub;
    sh  = {rem, quo[31]};
    sub = sh[31:0] - d;
    if (sh >= {1'b0, d})
      return {sub, quo[30:0], 1'b1};
    return {sh[31:0], quo[30:0], 1'b0};
  endfunction

  assign sgn = (funct3_i == FUNCT3_DIV) ||
               (funct3_i == FUNCT3_REM);
  assign div0 = (rs2_i == 32'd0);
  assign ovf = sgn && (rs1_i == 32'h8000_0000) &&
               (rs2_i == 32'hFFFF_FFFF);

  // 0x80000000 negates to itself, i.e. 2^31 unsigned.
  assign a_mag = (sgn && rs1_i[31]) ? -rs1_i : rs1_i;
  assign b_mag = (sgn && rs2_i[31]) ? -rs2_i : rs2_i;

  // The first step happens on the accept edge so that
  // 31 busy cycles complete all 32 quotient bits.
  assign first_step = div_step(32'd0, a_mag, b_mag);
  assign next_step  = div_step(rem_q, quo_q, dvsr_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      D_IDLE: begin
        if (start_i)
          state_d = (div0 || ovf) ? D_DONE : D_BUSY;
      end
      D_BUSY: begin
        if (cnt_q == 5'd1)
          state_d = D_DONE;
      end
      D_DONE: begin
        if (grant_i)
          state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
    if (kill_i)
      state_d = D_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= D_IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == D_IDLE && start_i) begin
        tag_q    <= tag_i;
        is_rem_q <= funct3_i[1];
        dvsr_q   <= b_mag;
        cnt_q    <= 5'd31;
        if (div0) begin
          quo_q   <= 32'hFFFF_FFFF;
          rem_q   <= rs1_i;
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
        end else if (ovf) begin
          quo_q   <= 32'h8000_0000;
          rem_q   <= 32'd0;
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
        end else begin
          {rem_q, quo_q} <= first_step;
          q_neg_q <= sgn && (rs1_i[31] ^ rs2_i[31]);
          r_neg_q <= sgn && rs1_i[31];
        end
      end else if (state_q == D_BUSY) begin
        {rem_q, quo_q} <= next_step;
        cnt_q <= cnt_q - 5'd1;
      end
    end
  end

  assign done_o = (state_q == D_DONE);
  assign idle_o = (state_q == D_IDLE);
  assign tag_o  = tag_q;

  always_comb begin
    result_o = 32'd0;
    if (is_rem_q)
      result_o = r_neg_q ? -rem_q : rem_q;
    else
      result_o = q_neg_q ? -quo_q : quo_q;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M issue controller: mul scheduling, divider, writeback arbiter.
// Ports: req handshake, mul_* to external multiplier, wb_* result, flush.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter int TAG_W       = TAG_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      rs1_value_i,
  input  logic [31:0]      rs2_value_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             mul_request_o,
  output logic [31:0]      mul_inst_o,
  output logic [31:0]      mul_rs1_o,
  output logic [31:0]      mul_rs2_o,
  input  logic [31:0]      mul_result_i,
  output logic             wb_valid_o,
  output logic [31:0]      wb_value_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             div_busy_o
);

  logic             is_div;
  logic             fire;
  logic             mul_fire;
  logic             div_start;
  logic             div_done;
  logic             div_idle;
  logic             div_grant;
  logic [31:0]      div_result;
  logic [TAG_W-1:0] div_tag;

  logic [MUL_LATENCY-1:0] mv_q;
  logic [TAG_W-1:0]       mt_q [MUL_LATENCY];
  logic                   mul_out;
  logic [TAG_W-1:0]       mul_out_tag;

  assign is_div = inst_i[14];

  // MUL stalls while a divide result waits, which bounds
  // how long the divider can be starved at writeback.
  assign req_ready_o = !reset_i && !flush_i &&
                       (is_div ? div_idle : !div_done);

  assign fire      = req_valid_i && req_ready_o;
  assign mul_fire  = fire && !is_div;
  assign div_start = fire && is_div;

  assign mul_request_o = mul_fire;
  assign mul_inst_o    = inst_i;
  assign mul_rs1_o = (req_valid_i && !is_div) ? rs1_value_i : 32'd0;
  assign mul_rs2_o = (req_valid_i && !is_div) ? rs2_value_i : 32'd0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mv_q <= '0;
      for (int i = 0; i < MUL_LATENCY; i++)
        mt_q[i] <= '0;
    end else begin
      mv_q[0] <= mul_fire;
      mt_q[0] <= tag_i;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        mv_q[i] <= mv_q[i-1];
        mt_q[i] <= mt_q[i-1];
      end
      if (flush_i)
        mv_q <= '0;
    end
  end

  assign mul_out     = mv_q[MUL_LATENCY-1];
  assign mul_out_tag = mt_q[MUL_LATENCY-1];

  div_iter #(
    .TAG_W(TAG_W)
  ) u_div (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (div_start),
    .rs1_i    (rs1_value_i),
    .rs2_i    (rs2_value_i),
    .funct3_i (inst_i[14:12]),
    .tag_i    (tag_i),
    .grant_i  (div_grant),
    .kill_i   (flush_i),
    .done_o   (div_done),
    .idle_o   (div_idle),
    .result_o (div_result),
    .tag_o    (div_tag)
  );

  assign div_busy_o = !div_idle;

  // Multiplier output always wins; divider takes free slots.
  assign div_grant = !reset_i && !flush_i && !mul_out && div_done;
  assign wb_valid_o = !reset_i && !flush_i && (mul_out || div_done);

  always_comb begin
    wb_value_o = 32'd0;
    wb_tag_o   = '0;
    if (mul_out) begin
      wb_value_o = mul_result_i;
      wb_tag_o   = mul_out_tag;
    end else if (div_done) begin
      wb_value_o = div_result;
      wb_tag_o   = div_tag;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed scoreboard bench for muldiv_ctrl with a 1-cycle multiplier stand-in.
// Checks latency, arbitration, special cases and flush.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   inst_i;
  logic [31:0]   rs1_value_i;
  logic [31:0]   rs2_value_i;
  logic [TW-1:0] tag_i;
  logic          flush_i;
  logic          mul_request_o;
  logic [31:0]   mul_inst_o;
  logic [31:0]   mul_rs1_o;
  logic [31:0]   mul_rs2_o;
  logic [31:0]   mul_result_i;
  logic          wb_valid_o;
  logic [31:0]   wb_value_o;
  logic [TW-1:0] wb_tag_o;
  logic          div_busy_o;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .MUL_LATENCY(1),
    .TAG_W(TW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .inst_i        (inst_i),
    .rs1_value_i   (rs1_value_i),
    .rs2_value_i   (rs2_value_i),
    .tag_i         (tag_i),
    .flush_i       (flush_i),
    .mul_request_o (mul_request_o),
    .mul_inst_o    (mul_inst_o),
    .mul_rs1_o     (mul_rs1_o),
    .mul_rs2_o     (mul_rs2_o),
    .mul_result_i  (mul_result_i),
    .wb_valid_o    (wb_valid_o),
    .wb_value_o    (wb_value_o),
    .wb_tag_o      (wb_tag_o),
    .div_busy_o    (div_busy_o)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   val;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'h01, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction

  // Stand-in for the external multiplier, one-cycle latency.
  function automatic logic [31:0] mref(input logic [2:0] f,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic [65:0] ea;
    logic [65:0] eb;
    logic [65:0] p;
    ea = (f == FUNCT3_MULHU) ? {34'd0, a} : {{34{a[31]}}, a};
    eb = (f == FUNCT3_MULHSU || f == FUNCT3_MULHU) ?
         {34'd0, b} : {{34{b[31]}}, b};
    p = ea * eb;
    return (f == FUNCT3_MUL) ? p[31:0] : p[63:32];
  endfunction

  always @(posedge clk)
    if (mul_request_o)
      mul_result_i <= mref(mul_inst_o[14:12], mul_rs1_o, mul_rs2_o);

  always @(negedge clk) begin : mon
    int idx;
    idx = -1;
    if (!reset_i && wb_valid_o) begin
      foreach (sb[i])
        if (sb[i].tag == wb_tag_o) idx = i;
      n_cmp++;
      assert (idx >= 0) else begin
        n_bad++;
        $error("FAIL sb_unexpected observed tag=%h value=%h expected=none",
               wb_tag_o, wb_value_o);
      end
      if (idx >= 0) begin
        chk("sb_value", wb_value_o, sb[idx].val);
        sb.delete(idx);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] t);
    req_valid_i = 1'b1;
    inst_i      = mk(f3);
    rs1_value_i = a;
    rs2_value_i = b;
    tag_i       = t;
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic wait_wb(input int exp, input string nm);
    int k;
    k = 1;
    forever begin
      @(negedge clk);
      if (wb_valid_o || k >= 80) break;
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, k, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i      = 1'b1;
    req_valid_i  = 1'b0;
    flush_i      = 1'b0;
    inst_i       = mk(FUNCT3_MUL);
    rs1_value_i  = 32'd0;
    rs2_value_i  = 32'd0;
    tag_i        = '0;
    mul_result_i = 32'd0;

    cyc();
    req_valid_i = 1'b1;
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_mulreq", mul_request_o, 0);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_wb", wb_valid_o, 0);
    chk("rst_busy", div_busy_o, 0);
    cyc();
    reset_i = 1'b0;

    // MUL 7*6
    cyc();
    drive(FUNCT3_MUL, 32'd7, 32'd6, 5'd3);
    push(5'd3, 32'd42);
    #1;
    chk("t1_ready", req_ready_o, 1);
    chk("t1_mulreq", mul_request_o, 1);
    chk("t1_rs1", mul_rs1_o, 32'd7);
    cyc();
    req_valid_i = 1'b0;
    wait_wb(1, "t1_lat");
    chk("t1_tag", wb_tag_o, 32'd3);

    // back-to-back MULHU then MULH
    cyc();
    drive(FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    push(5'd4, 32'hFFFF_FFFE);
    cyc();
    drive(FUNCT3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
    push(5'd5, 32'd0);
    @(negedge clk);
    chk("t2_wb1", wb_valid_o, 1);
    chk("t2_tag1", wb_tag_o, 32'd4);
    cyc();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("t2_wb2", wb_valid_o, 1);
    chk("t2_tag2", wb_tag_o, 32'd5);

    // DIV -7/2, REM -7/2
    cyc();
    drive(FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9);
    push(5'd9, 32'hFFFF_FFFD);
    #1;
    chk("t3_mulreq", mul_request_o, 0);
    chk("t3_mulrs1", mul_rs1_o, 0);
    cyc();
    drive(FUNCT3_DIV, 32'd1, 32'd1, 5'd20);
    #1;
    chk("t3_busy_ready", req_ready_o, 0);
    chk("t3_busy", div_busy_o, 1);
    req_valid_i = 1'b0;
    wait_wb(32, "t3_div_lat");
    chk("t3_div_tag", wb_tag_o, 32'd9);
    cyc();
    drive(FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 5'd10);
    push(5'd10, 32'hFFFF_FFFF);
    cyc();
    req_valid_i = 1'b0;
    wait_wb(32, "t3_rem_lat");

    // special cases
    cyc();
    drive(FUNCT3_DIVU, 32'd5, 32'd0, 5'd11);
    push(5'd11, 32'hFFFF_FFFF);
    cyc();
    req_valid_i = 1'b0;
    wait_wb(1, "t4_divu0_lat");
    cyc();
    drive(FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    push(5'd12, 32'd0);
    cyc();
    req_valid_i = 1'b0;
    wait_wb(1, "t4_rem_ovf_lat");
    cyc();
    drive(FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    push(5'd13, 32'h8000_0000);
    cyc();
    req_valid_i = 1'b0;
    wait_wb(1, "t4_div_ovf_lat");
    cyc();
    drive(FUNCT3_REM, 32'hFFFF_FFF9, 32'd0, 5'd21);
    push(5'd21, 32'hFFFF_FFF9);
    cyc();
    req_valid_i = 1'b0;
    wait_wb(1, "t4_rem0_lat");

    // divider done collides with a mul result
    cyc();
    drive(FUNCT3_DIVU, 32'd100, 32'd7, 5'd14);
    push(5'd14, 32'd14);
    cyc();
    req_valid_i = 1'b0;
    repeat (30) cyc();
    drive(FUNCT3_MUL, 32'd3, 32'd5, 5'd15);
    push(5'd15, 32'd15);
    #1;
    chk("t5_mul_ready", req_ready_o, 1);
    cyc();
    drive(FUNCT3_MUL, 32'd2, 32'd2, 5'd22);
    #1;
    chk("t5_mul_stall", req_ready_o, 0);
    @(negedge clk);
    chk("t5_first_wb", wb_valid_o, 1);
    chk("t5_first_tag", wb_tag_o, 32'd15);
    cyc();
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("t5_second_wb", wb_valid_o, 1);
    chk("t5_second_tag", wb_tag_o, 32'd14);

    // flush mid-divide with a mul in flight
    cyc();
    drive(FUNCT3_DIV, 32'd1000, 32'd3, 5'd16);
    push(5'd16, 32'd333);
    cyc();
    req_valid_i = 1'b0;
    repeat (8) cyc();
    drive(FUNCT3_MUL, 32'd4, 32'd4, 5'd17);
    push(5'd17, 32'd16);
    cyc();
    drive(FUNCT3_DIV, 32'd9, 32'd3, 5'd23);
    flush_i = 1'b1;
    #1;
    chk("t6_flush_ready", req_ready_o, 0);
    @(negedge clk);
    chk("t6_flush_wb", wb_valid_o, 0);
    sb.delete();
    cyc();
    flush_i = 1'b0;
    drive(FUNCT3_DIV, 32'd20, 32'd4, 5'd18);
    #1;
    chk("t6_idle", div_busy_o, 0);
    chk("t6_ready", req_ready_o, 1);
    push(5'd18, 32'd5);
    cyc();
    req_valid_i = 1'b0;
    wait_wb(32, "t6_new_div_lat");
    chk("t6_new_tag", wb_tag_o, 32'd18);

    repeat (4) cyc();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
